// File: rtl/spi_avalon_bridge.sv
// SPI-slave (mode 0, MSB first) to Avalon-MM master bridge with auto-increment
// bursts, a prefetching read path, an acknowledge timeout and an error counter.
// The SPI pins are oversampled in the clk domain (clk >= 4x spi_clk).
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   spi_clk, csn, mosi          SPI slave inputs
//   miso, miso_oe               SPI data out and its tri-state enable
//   av_*                        Avalon-MM master interface
//   busy                        frame in progress or bus transaction pending
//   err_timeout, err_count      timeout pulse and saturating error count
module spi_avalon_bridge #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_clk,
  input  logic                csn,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic                av_read,
  output logic                av_write,
  output logic [ADDR_W-1:0]   av_address,
  output logic [DATA_W/8-1:0] av_byte_enable,
  output logic [DATA_W-1:0]   av_write_data,
  input  logic [DATA_W-1:0]   av_read_data,
  input  logic                av_acknowledge,
  output logic                busy,
  output logic                err_timeout,
  output logic [7:0]          err_count
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SR_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(SR_W);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BE_W);

  typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_WDATA, F_RDUMMY, F_RDATA} frame_state_t;
  typedef enum logic {BUS_IDLE, BUS_REQ} bus_state_t;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, csn_sync_q, csn_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, csn_prev_q, csn_prev_d;
  frame_state_t frame_q, frame_d;
  bus_state_t   bus_q, bus_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SR_W-2:0]   rx_q, rx_d;
  logic              is_read_q, is_read_d, incr_q, incr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-2:0] tx_q, tx_d;
  logic              miso_q, miso_d, miso_oe_q, miso_oe_d, busy_q, busy_d;
  req_t              pend_q, pend_d, new_req_p;
  logic              pend_valid_q, pend_valid_d, new_req, consume;
  logic              av_read_q, av_read_d, av_write_q, av_write_d;
  logic [ADDR_W-1:0] av_address_q, av_address_d;
  logic [BE_W-1:0]   av_byte_enable_q, av_byte_enable_d;
  logic [DATA_W-1:0] av_write_data_q, av_write_data_d, rd_buf_q, rd_buf_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_timeout_q, err_timeout_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;

  logic sclk_s, csn_s, mosi_s, sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [SR_W-1:0]   rx_shift;
  logic [ADDR_W-1:0] step;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign csn_fall  = ~csn_s & csn_prev_q;
  assign rx_shift  = {rx_q, mosi_s};
  assign step      = incr_q ? ADDR_STEP : '0;

  // Pin synchronisers and edge-detect history.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], csn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    csn_prev_d  = csn_s;
    miso_oe_d   = ~csn_s;
    busy_d      = (frame_q != F_IDLE) || (bus_q == BUS_REQ) || pend_valid_q;
  end

  // Frame FSM: decodes the SPI byte stream and raises word requests.
  always_comb begin
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    is_read_d = is_read_q;
    incr_d    = incr_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    new_req   = 1'b0;
    new_req_p = '0;
    if (csn_rise) begin
      frame_d   = F_IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      miso_d    = 1'b0;
    end else begin
      case (frame_q)
        F_IDLE: if (csn_fall) begin
          frame_d   = F_CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
          miso_d    = 1'b0;
        end
        F_CMD: if (sclk_rise) begin
          rx_d      = rx_shift[SR_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            is_read_d = rx_shift[7];
            incr_d    = rx_shift[6];
            bit_cnt_d = '0;
            frame_d   = F_ADDR;
          end
        end
        F_ADDR: if (sclk_rise) begin
          rx_d      = rx_shift[SR_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            addr_d    = rx_shift[ADDR_W-1:0];
            if (is_read_q) begin
              // First read goes out now so it lands during the dummy byte.
              frame_d        = F_RDUMMY;
              new_req        = 1'b1;
              new_req_p.addr = rx_shift[ADDR_W-1:0];
              addr_d         = rx_shift[ADDR_W-1:0] + step;
            end else begin
              frame_d = F_WDATA;
            end
          end
        end
        F_WDATA: if (sclk_rise) begin
          rx_d      = rx_shift[SR_W-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d       = '0;
            new_req         = 1'b1;
            new_req_p.write = 1'b1;
            new_req_p.addr  = addr_q;
            new_req_p.data  = rx_shift[DATA_W-1:0];
            addr_d          = addr_q + step;
          end
        end
        F_RDUMMY: if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            bit_cnt_d = '0;
            frame_d   = F_RDATA;
          end
        end
        F_RDATA: begin
          if (sclk_rise) begin
            bit_cnt_d = (bit_cnt_q == CNT_W'(DATA_W - 1)) ? '0 : bit_cnt_q + CNT_W'(1);
            // Prefetch on the first rise of a word so the trailing fall of
            // the frame does not launch a read nobody will clock out.
            if (bit_cnt_q == '0) begin
              new_req        = 1'b1;
              new_req_p.addr = addr_q;
              addr_d         = addr_q + step;
            end
          end
          if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
              miso_d = rd_buf_q[DATA_W-1];
              tx_d   = rd_buf_q[DATA_W-2:0];
            end else begin
              miso_d = tx_q[DATA_W-2];
              tx_d   = {tx_q[DATA_W-3:0], 1'b0};
            end
          end
        end
        default: frame_d = F_IDLE;
      endcase
    end
  end

  // Bus FSM: one outstanding Avalon request, one-deep pending slot.
  always_comb begin
    bus_d            = bus_q;
    pend_d           = pend_q;
    pend_valid_d     = pend_valid_q;
    av_read_d        = av_read_q;
    av_write_d       = av_write_q;
    av_address_d     = av_address_q;
    av_byte_enable_d = av_byte_enable_q;
    av_write_data_d  = av_write_data_q;
    rd_buf_d         = rd_buf_q;
    timer_d          = timer_q;
    err_timeout_d    = 1'b0;
    err_inc          = 2'd0;
    consume          = 1'b0;
    case (bus_q)
      BUS_IDLE: if (pend_valid_q) begin
        consume          = 1'b1;
        bus_d            = BUS_REQ;
        av_write_d       = pend_q.write;
        av_read_d        = ~pend_q.write;
        av_address_d     = pend_q.addr;
        av_byte_enable_d = '1;
        timer_d          = '0;
        if (pend_q.write) av_write_data_d = pend_q.data;
      end
      BUS_REQ: begin
        if (av_acknowledge) begin
          bus_d            = BUS_IDLE;
          av_read_d        = 1'b0;
          av_write_d       = 1'b0;
          av_byte_enable_d = '0;
          if (av_read_q) rd_buf_d = av_read_data;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          bus_d            = BUS_IDLE;
          av_read_d        = 1'b0;
          av_write_d       = 1'b0;
          av_byte_enable_d = '0;
          err_timeout_d    = 1'b1;
          err_inc          = 2'd1;
          if (av_read_q) rd_buf_d = '1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: bus_d = BUS_IDLE;
    endcase
    if (consume) pend_valid_d = 1'b0;
    if (new_req) begin
      if (!pend_valid_q || consume) begin
        pend_d       = new_req_p;
        pend_valid_d = 1'b1;
      end else begin
        err_inc = err_inc + 2'd1;
      end
    end
    err_sum     = {1'b0, err_count_q} + 9'(err_inc);
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q      <= '0;
      csn_sync_q       <= '1;
      mosi_sync_q      <= '0;
      sclk_prev_q      <= 1'b0;
      csn_prev_q       <= 1'b1;
      frame_q          <= F_IDLE;
      bus_q            <= BUS_IDLE;
      bit_cnt_q        <= '0;
      rx_q             <= '0;
      is_read_q        <= 1'b0;
      incr_q           <= 1'b0;
      addr_q           <= '0;
      tx_q             <= '0;
      miso_q           <= 1'b0;
      miso_oe_q        <= 1'b0;
      busy_q           <= 1'b0;
      pend_q           <= '0;
      pend_valid_q     <= 1'b0;
      av_read_q        <= 1'b0;
      av_write_q       <= 1'b0;
      av_address_q     <= '0;
      av_byte_enable_q <= '0;
      av_write_data_q  <= '0;
      rd_buf_q         <= '0;
      timer_q          <= '0;
      err_timeout_q    <= 1'b0;
      err_count_q      <= '0;
    end else begin
      sclk_sync_q      <= sclk_sync_d;
      csn_sync_q       <= csn_sync_d;
      mosi_sync_q      <= mosi_sync_d;
      sclk_prev_q      <= sclk_prev_d;
      csn_prev_q       <= csn_prev_d;
      frame_q          <= frame_d;
      bus_q            <= bus_d;
      bit_cnt_q        <= bit_cnt_d;
      rx_q             <= rx_d;
      is_read_q        <= is_read_d;
      incr_q           <= incr_d;
      addr_q           <= addr_d;
      tx_q             <= tx_d;
      miso_q           <= miso_d;
      miso_oe_q        <= miso_oe_d;
      busy_q           <= busy_d;
      pend_q           <= pend_d;
      pend_valid_q     <= pend_valid_d;
      av_read_q        <= av_read_d;
      av_write_q       <= av_write_d;
      av_address_q     <= av_address_d;
      av_byte_enable_q <= av_byte_enable_d;
      av_write_data_q  <= av_write_data_d;
      rd_buf_q         <= rd_buf_d;
      timer_q          <= timer_d;
      err_timeout_q    <= err_timeout_d;
      err_count_q      <= err_count_d;
    end
  end

  assign miso           = miso_q;
  assign miso_oe        = miso_oe_q;
  assign av_read        = av_read_q;
  assign av_write       = av_write_q;
  assign av_address     = av_address_q;
  assign av_byte_enable = av_byte_enable_q;
  assign av_write_data  = av_write_data_q;
  assign busy           = busy_q;
  assign err_timeout    = err_timeout_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_spi_avalon_bridge.sv
// Directed bench for spi_avalon_bridge: SPI master driver, Avalon slave model
// with a transaction log, and hand-computed expected values.
module tb_spi_avalon_bridge;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, av_read, av_write, busy, err_timeout;
  logic [31:0] av_address, av_write_data;
  logic [3:0]  av_byte_enable;
  logic [31:0] av_read_data = 32'h0;
  logic        av_acknowledge = 1'b0;
  logic [7:0]  err_count;

  int vectors = 0;
  int miscompares = 0;

  logic        slave_en = 1'b1;
  logic [31:0] rd_mem [4];
  int          rd_i = 0;
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_be   [16];
  int          wr_n = 0;
  logic [31:0] rd_addr [16];
  int          rd_n = 0;
  logic        rd_prev = 1'b0;
  int          rd_cyc = 0;
  int          to_pulses = 0;

  spi_avalon_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .av_read(av_read), .av_write(av_write),
    .av_address(av_address), .av_byte_enable(av_byte_enable),
    .av_write_data(av_write_data), .av_read_data(av_read_data),
    .av_acknowledge(av_acknowledge), .busy(busy), .err_timeout(err_timeout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Avalon slave: single-cycle ack one cycle after a request is seen.
  always @(negedge clk) begin
    if (av_acknowledge) begin
      av_acknowledge = 1'b0;
    end else if (slave_en && (av_read || av_write)) begin
      av_acknowledge = 1'b1;
      if (av_write && wr_n < 16) begin
        wr_addr[wr_n] = av_address;
        wr_data[wr_n] = av_write_data;
        wr_be[wr_n]   = av_byte_enable;
        wr_n++;
      end
      if (av_read && rd_i < 4) begin
        av_read_data = rd_mem[rd_i];
        rd_i++;
      end
    end
  end

  // Read-request, read-cycle and timeout-pulse monitor.
  always @(negedge clk) begin
    if (av_read && !rd_prev && rd_n < 16) begin
      rd_addr[rd_n] = av_address;
      rd_n++;
    end
    rd_prev = av_read;
    if (av_read) rd_cyc++;
    if (err_timeout) to_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] got);
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      repeat (HALF) @(negedge clk);
      got = {got[30:0], miso};
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    csn = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    csn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int w0, r0, c0, t0;
    rd_mem[0] = 32'h11111111;
    rd_mem[1] = 32'h22222222;
    rd_mem[2] = 32'h33333333;
    rd_mem[3] = 32'h44444444;

    repeat (3) @(negedge clk);
    check("rst_av_write", 32'(av_write), 32'd0);
    check("rst_av_read", 32'(av_read), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_be", 32'(av_byte_enable), 32'd0);

    // Single write, no increment.
    cs_low();
    spi_bits(32'h00, 8, got);
    check("wr_busy_mid", 32'(busy), 32'd1);
    check("wr_oe_mid", 32'(miso_oe), 32'd1);
    spi_bits(32'h00000010, 32, got);
    spi_bits(32'hCAFEBABE, 32, got);
    cs_high();
    wait_idle("wr_idle");
    check("wr_count", 32'(wr_n), 32'd1);
    check("wr_addr", wr_addr[0], 32'h10);
    check("wr_data", wr_data[0], 32'hCAFEBABE);
    check("wr_be", 32'(wr_be[0]), 32'hF);
    check("wr_err", 32'(err_count), 32'd0);

    // Burst write with auto-increment.
    cs_low();
    spi_bits(32'h40, 8, got);
    spi_bits(32'h00000100, 32, got);
    spi_bits(32'd1, 32, got);
    spi_bits(32'd2, 32, got);
    spi_bits(32'd3, 32, got);
    cs_high();
    wait_idle("bw_idle");
    check("bw_count", 32'(wr_n), 32'd4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bw_addr%0d", k), wr_addr[k+1], 32'h100 + 32'(4 * k));
      check($sformatf("bw_data%0d", k), wr_data[k+1], 32'(k + 1));
    end

    // Burst read with auto-increment and prefetch.
    cs_low();
    spi_bits(32'hC0, 8, got);
    spi_bits(32'h00000200, 32, got);
    spi_bits(32'h00, 8, got);
    check("br_dummy", got, 32'h0);
    spi_bits(32'h0, 32, got);
    check("br_word0", got, 32'h11111111);
    spi_bits(32'h0, 32, got);
    check("br_word1", got, 32'h22222222);
    cs_high();
    wait_idle("br_idle");
    check("br_rd_count", 32'(rd_n), 32'd3);
    check("br_addr0", rd_addr[0], 32'h200);
    check("br_addr1", rd_addr[1], 32'h204);
    check("br_addr2", rd_addr[2], 32'h208);

    // Read timeout: no ack, 16-cycle limit.
    slave_en = 1'b0;
    r0 = rd_n;
    c0 = rd_cyc;
    t0 = to_pulses;
    cs_low();
    spi_bits(32'h80, 8, got);
    spi_bits(32'h00000300, 32, got);
    spi_bits(32'h00, 8, got);
    check("to_rd_cycles", 32'(rd_cyc - c0), 32'd16);
    check("to_pulses", 32'(to_pulses - t0), 32'd1);
    check("to_err_count", 32'(err_count), 32'd1);
    spi_bits(32'h0, 32, got);
    check("to_word", got, 32'hFFFFFFFF);
    cs_high();
    wait_idle("to_idle");
    // The word-start prefetch of the same address also times out.
    check("to_prefetch_addr", rd_addr[rd_n-1], 32'h300);
    check("to_rd_count", 32'(rd_n - r0), 32'd2);
    check("to_err_count2", 32'(err_count), 32'd2);
    check("to_pulses2", 32'(to_pulses - t0), 32'd2);
    slave_en = 1'b1;

    // Abort after 12 data bits: no write for the partial word.
    w0 = wr_n;
    cs_low();
    spi_bits(32'h00, 8, got);
    spi_bits(32'h00000040, 32, got);
    spi_bits(32'hABC, 12, got);
    cs_high();
    wait_idle("ab_idle");
    repeat (20) @(negedge clk);
    check("ab_no_write", 32'(wr_n - w0), 32'd0);
    check("ab_av_write", 32'(av_write), 32'd0);

    // Reset while av_write is held.
    slave_en = 1'b0;
    cs_low();
    spi_bits(32'h00, 8, got);
    spi_bits(32'h00000050, 32, got);
    spi_bits(32'h12345678, 32, got);
    for (int i = 0; i < 50; i++) begin
      if (av_write) break;
      @(negedge clk);
    end
    check("rr_write_seen", 32'(av_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rr_av_write", 32'(av_write), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_miso_oe", 32'(miso_oe), 32'd0);
    check("rr_err_count", 32'(err_count), 32'd0);
    check("rr_be", 32'(av_byte_enable), 32'd0);
    csn = 1'b1;
    slave_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    w0 = wr_n;
    cs_low();
    spi_bits(32'h00, 8, got);
    spi_bits(32'h00000060, 32, got);
    spi_bits(32'hA5A5A5A5, 32, got);
    cs_high();
    wait_idle("rr_idle");
    check("rr_count", 32'(wr_n - w0), 32'd1);
    check("rr_addr", wr_addr[wr_n-1], 32'h60);
    check("rr_data", wr_data[wr_n-1], 32'hA5A5A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
